// File: rtl/mac_beat_issuer_pkg.sv
// mac_pkg: shared widths, lane legality and FSM states for mac_beat_issuer
package mac_pkg;
  localparam int MAX_LANES = 16;
  localparam int W_IN = 20;
  localparam int W_ADDR = 10;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  function automatic logic lane_legal(input logic [4:0] l);
    return l == 5'd1 || l == 5'd2 || l == 5'd4 || l == 5'd8 || l == 5'd16;
  endfunction
endpackage

// File: rtl/mac_beat_issuer_if.sv
// mac_beat_issuer_if: operand-buffer and partial-sum stream bundle; ps_last exists under MAC_BEAT_LAST_EN
interface mac_beat_issuer_if;
  logic start;
  logic [4:0] lanes_i;
  logic rd_en;
  logic [mac_pkg::W_ADDR-1:0] rd_addr;
  logic [8*mac_pkg::MAX_LANES-1:0] rd_data_a;
  logic [8*mac_pkg::MAX_LANES-1:0] rd_data_b;
  logic in_valid;
  logic [mac_pkg::W_IN-1:0] partial_sum;
  logic busy;
  logic done;
  logic cfg_err;
`ifdef MAC_BEAT_LAST_EN
  logic ps_last;
  modport master (input start, lanes_i, rd_data_a, rd_data_b,
                  output rd_en, rd_addr, in_valid, partial_sum, busy, done, cfg_err, ps_last);
  modport slave (output start, lanes_i, rd_data_a, rd_data_b,
                 input rd_en, rd_addr, in_valid, partial_sum, busy, done, cfg_err, ps_last);
`else
  modport master (input start, lanes_i, rd_data_a, rd_data_b,
                  output rd_en, rd_addr, in_valid, partial_sum, busy, done, cfg_err);
  modport slave (output start, lanes_i, rd_data_a, rd_data_b,
                 input rd_en, rd_addr, in_valid, partial_sum, busy, done, cfg_err);
`endif
endinterface

// File: rtl/mac_beat_issuer_lane_dot_reduce.sv
// lane_dot_reduce: masked lane-wise uint8 products summed into one partial sum
module lane_dot_reduce import mac_pkg::*; #(
  parameter int ELEMS = 1000
) (
  input  logic [8*MAX_LANES-1:0] a,
  input  logic [8*MAX_LANES-1:0] b,
  input  logic [W_ADDR-1:0]      base,
  input  logic [4:0]             lanes,
  output logic [W_IN-1:0]        sum
);
  always_comb begin
    sum = '0;
    for (int k = 0; k < MAX_LANES; k++)
      if (k < int'(lanes) && int'(base) + k < ELEMS)
        sum += W_IN'({8'd0, a[8*k+:8]} * {8'd0, b[8*k+:8]});
  end
endmodule

// File: rtl/mac_beat_issuer.sv
// mac_beat_issuer: issues operand reads and streams lane dot products, 2-cycle read-to-valid latency
// Optional MAC_BEAT_LAST_EN adds ps_last on the final beat.
module mac_beat_issuer import mac_pkg::*; #(
  parameter int ELEMS = 1000
) (
  input logic clk,
  input logic rst_n,
  mac_beat_issuer_if.master bus
);
  state_t state, state_n;
  logic [W_ADDR:0] addr, next_addr;
  logic [W_ADDR-1:0] addr_d1;
  logic [4:0] lanes_q;
  logic drain_cnt, v1, last;
  logic [W_IN-1:0] sum_c;
  assign next_addr = addr + {{(W_ADDR-4){1'b0}}, lanes_q};
  assign last = next_addr >= (W_ADDR+1)'(ELEMS);
  assign bus.rd_en = state == ISSUE;
  assign bus.rd_addr = addr[W_ADDR-1:0];
  assign bus.busy = state == ISSUE || state == DRAIN;
  assign bus.done = state == DONE;
  always_comb begin
    state_n = state == IDLE  ? (bus.start ? ISSUE : IDLE) :
              state == ISSUE ? (last ? DRAIN : ISSUE) :
              state == DRAIN ? (drain_cnt ? DONE : DRAIN) : IDLE;
  end
  // data arriving this cycle belongs to last cycle's address
  lane_dot_reduce #(.ELEMS(ELEMS)) u_reduce (
    .a(bus.rd_data_a), .b(bus.rd_data_b), .base(addr_d1), .lanes(lanes_q), .sum(sum_c)
  );
`ifdef MAC_BEAT_LAST_EN
  logic l1;
  always_ff @(posedge clk) begin
    l1 <= rst_n && bus.rd_en && last;
    bus.ps_last <= rst_n && l1;
  end
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      addr_d1 <= '0;
      lanes_q <= '0;
      drain_cnt <= 1'b0;
      v1 <= 1'b0;
      bus.in_valid <= 1'b0;
      bus.partial_sum <= '0;
      bus.cfg_err <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.start) begin
        addr <= '0;
        lanes_q <= lane_legal(bus.lanes_i) ? bus.lanes_i : 5'd1;
        bus.cfg_err <= !lane_legal(bus.lanes_i);
      end else if (state == ISSUE) addr <= next_addr;
      drain_cnt <= state == DRAIN && !drain_cnt;
      v1 <= bus.rd_en;
      addr_d1 <= addr[W_ADDR-1:0];
      bus.in_valid <= v1;
      bus.partial_sum <= v1 ? sum_c : '0;
    end
  end
endmodule
